// File: rtl/div_pkg.sv
// Shared types and sizing constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH_DEFAULT = 8;
   localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT + 1);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, and keep the difference only when it does not borrow.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   r_i,
   input  logic             q_msb_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH:0]   r_o,
   output logic             q_bit_o,
   output logic             borrow_o
);

   logic [WIDTH:0] r_sh;
   logic [WIDTH:0] diff;

   // Subtraction as an add of the inverted divisor with carry-in 1; WIDTH+1 bits
   // so the shifted partial remainder (< 2*D) can never overflow.
   always_comb begin
      r_sh     = {r_i[WIDTH-1:0], q_msb_i};
      diff     = r_sh + ~{1'b0, d_i} + {{WIDTH{1'b0}}, 1'b1};
      borrow_o = diff[WIDTH];
      q_bit_o  = ~diff[WIDTH];
      r_o      = diff[WIDTH] ? r_sh : diff;
   end

endmodule

// File: rtl/seq_div_8bit.sv
// Sequential unsigned restoring divider with start/done handshake; one quotient
// bit per clock, divide-by-zero answered in a single cycle.
module seq_div_8bit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH == DIV_WIDTH_DEFAULT) ? DIV_CNT_W : $clog2(WIDTH + 1);

   div_state_t       state_q, state_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   step_r;
   logic             step_qbit;
   logic             step_borrow;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_i      (r_q),
      .q_msb_i  (q_q[WIDTH-1]),
      .d_i      (d_q),
      .r_o      (step_r),
      .q_bit_o  (step_qbit),
      .borrow_o (step_borrow)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               if (divisor == '0) begin
                  state_d = DONE;
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = RUN;
                  r_d     = '0;
                  q_d     = dividend;
                  d_d     = divisor;
                  cnt_d   = CNT_W'(WIDTH);
               end
            end
         end
         RUN: begin
            r_d   = step_r;
            q_d   = {q_q[WIDTH-2:0], step_qbit};
            cnt_d = cnt_q - CNT_W'(1);
            // Results are published only on the final step, so partial Q/R stay hidden.
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               quo_d   = {q_q[WIDTH-2:0], step_qbit};
               rem_d   = step_r[WIDTH-1:0];
               dbz_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_8bit.sv
// Self-checking bench for seq_div_8bit: directed scenarios plus randomized
// operands checked against plain integer division.
module tb_seq_div_8bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   seq_div_8bit #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: plain integer division, with the defined divide-by-zero answer.
   function automatic void ref_div(input int a, input int b,
                                   output int q, output int r, output bit z);
      if (b == 0) begin
         q = 255; r = a; z = 1'b1;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endfunction

   // Issue one start and return the edge (counted from the start edge) at
   // which done is first sampled high; bounded so a dead DUT cannot hang.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
         n_err++;
         $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat;
      run_op(8'd200, 8'd7, lat);
      n_cmp++;
      if (lat !== 9) begin
         n_err++; $display("FAIL basic_latency: got %0d, want 9", lat);
      end
      n_cmp++;
      if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
         n_err++;
         $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=28 r=4 dbz=0",
                  quotient, remainder, div_by_zero);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4) begin
         n_err++;
         $display("FAIL basic_hold: got done=%b q=%0d r=%0d, want done=0 q=28 r=4",
                  done, quotient, remainder);
      end
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      @(negedge clk);
      start = 1'b1; dividend = 8'd200; divisor = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
         n_err++;
         $display("FAIL reset_mid_run: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++; $display("FAIL reset_discard: got busy/done activity=1, want 0");
      end
   endtask

   task automatic test_div_zero();
      int lat;
      @(negedge clk);
      start = 1'b1; dividend = 8'd93; divisor = 8'd0;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL dbz_latency: got done=%b busy=%b, want done=1 busy=0", done, busy);
      end
      n_cmp++;
      if (quotient !== 8'd255 || remainder !== 8'd93 || div_by_zero !== 1'b1) begin
         n_err++;
         $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b, want q=255 r=93 dbz=1",
                  quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
         n_err++;
         $display("FAIL dbz_after: got done=%b busy=%b dbz=%b, want 0 0 1", done, busy, div_by_zero);
      end
      run_op(8'd10, 8'd3, lat);
      n_cmp++;
      if (div_by_zero !== 1'b0 || quotient !== 8'd3 || remainder !== 8'd1) begin
         n_err++;
         $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b, want q=3 r=1 dbz=0",
                  quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_edges();
      logic [7:0] ea [4] = '{8'd5, 8'd255, 8'd255, 8'd0};
      logic [7:0] eb [4] = '{8'd9, 8'd1,   8'd255, 8'd3};
      logic [7:0] eq [4] = '{8'd0, 8'd255, 8'd1,   8'd0};
      logic [7:0] er [4] = '{8'd5, 8'd0,   8'd0,   8'd0};
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(ea[i], eb[i], lat);
         n_cmp++;
         if (lat !== 9 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL edge_%0d_%0d: got lat=%0d q=%0d r=%0d dbz=%b, want lat=9 q=%0d r=%0d dbz=0",
                     ea[i], eb[i], lat, quotient, remainder, div_by_zero, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      start = 1'b1; dividend = 8'd100; divisor = 8'd10;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; dividend = 8'd50; divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      lat = 4;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++;
      if (lat !== 9 || quotient !== 8'd10 || remainder !== 8'd0) begin
         n_err++;
         $display("FAIL b2b_ignored_start: got lat=%0d q=%0d r=%0d, want lat=9 q=10 r=0",
                  lat, quotient, remainder);
      end
      start = 1'b1; dividend = 8'd50; divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b1 || quotient !== 8'd10) begin
         n_err++;
         $display("FAIL b2b_restart: got done=%b busy=%b q=%0d, want done=0 busy=1 q=10",
                  done, busy, quotient);
      end
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++;
      if (lat !== 9 || quotient !== 8'd16 || remainder !== 8'd2) begin
         n_err++;
         $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d, want lat=9 q=16 r=2",
                  lat, quotient, remainder);
      end
   endtask

   task automatic test_random();
      int lat, eqv, erv, bad;
      bit ez;
      logic [7:0] a, b;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom);
         b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         ref_div(int'(a), int'(b), eqv, erv, ez);
         run_op(a, b, lat);
         n_cmp++;
         if (int'(quotient) != eqv || int'(remainder) != erv || div_by_zero !== ez ||
             lat != ((b == 0) ? 1 : 9)) begin
            n_err++;
            if (bad < 10)
               $display("FAIL random_%0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=%b",
                        a, b, quotient, remainder, div_by_zero, lat, eqv, erv, ez);
            bad++;
         end
         if (b != 0) begin
            n_cmp++;
            if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b) begin
               n_err++;
               $display("FAIL random_identity_%0d/%0d: got q=%0d r=%0d, want q*d+r=%0d and r<%0d",
                        a, b, quotient, remainder, a, b);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reset_mid_run();
      test_div_zero();
      test_edges();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
